program_loader: RTL and testbench

Writer side of the processor's instruction memory. Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the program memory write port at consecutive word addresses. Holds the processor in reset until a complete program has been written, then releases it. Sits between the board-level byte source (UART receiver or bench) and the program memory / processor reset.

---
 rtl/program_loader_if.sv | 34 +++
 rtl/program_loader.sv | 170 +++++++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
//==============================================================================
// program_loader_if: byte-stream, program-memory and status bundle of program_loader. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface program_loader_if;
  logic        start_i;
  logic [15:0] length_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        mem_write_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        cpu_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  modport master (
    output start_i, length_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, mem_write_o, mem_address_o, mem_data_o,
           cpu_reset_o, busy_o, done_o, error_o
  );

  modport slave (
    input  start_i, length_i, byte_valid_i, byte_data_i,
    output byte_ready_o, mem_write_o, mem_address_o, mem_data_o,
           cpu_reset_o, busy_o, done_o, error_o
  );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
//==============================================================================
// program_loader: assembles big-endian words from a byte stream into program memory, holding the CPU in reset.
// Optional trailer checksum byte via PROGRAM_LOADER_CHECKSUM_EN. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module program_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  program_loader_if.slave bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_RECV  = 3'd1;
  localparam logic [2:0] c_WRITE = 3'd2;
  localparam logic [2:0] c_DONE  = 3'd3;
  localparam logic [2:0] c_ERROR = 3'd4;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] c_CHECK = 3'd5;
`endif
  localparam logic [16:0] c_DEPTH = 17'(MEMORY_DEPTH);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_length;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_asm;
  logic [31:0] w_asm_next;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data;
  logic        r_byte_ready, r_mem_write, r_cpu_reset, r_busy, r_done, r_error;
  logic        w_byte_ready, w_mem_write, w_cpu_reset, w_busy, w_done, w_error;
  logic        w_len_bad;
  logic        w_take_start;
  logic        w_accept;
  logic        w_last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  assign w_len_bad    = (bus.length_i == 16'd0) || ({1'b0, bus.length_i} > c_DEPTH);
  assign w_take_start = bus.start_i &&
                        ((r_state == c_IDLE) || (r_state == c_DONE) || (r_state == c_ERROR));
  assign w_accept     = bus.byte_valid_i && (r_state == c_RECV);
  assign w_last_word  = ((r_word_cnt + 16'd1) == r_length);

  // Byte n of a word lands in bits [31-8n -: 8]
  always_comb begin
    w_asm_next = r_asm;
    case (r_byte_cnt)
      2'd0:    w_asm_next[31:24] = bus.byte_data_i;
      2'd1:    w_asm_next[23:16] = bus.byte_data_i;
      2'd2:    w_asm_next[15:8]  = bus.byte_data_i;
      default: w_asm_next[7:0]   = bus.byte_data_i;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_write  <= 1'b0;
      r_cpu_reset  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= w_byte_ready;
      r_mem_write  <= w_mem_write;
      r_cpu_reset  <= w_cpu_reset;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_error      <= w_error;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE, c_DONE, c_ERROR: begin
        if (bus.start_i) w_next = w_len_bad ? c_ERROR : c_RECV;
      end
      c_RECV: begin
        if (w_accept && (r_byte_cnt == 2'd3)) w_next = c_WRITE;
      end
      c_WRITE: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        w_next = w_last_word ? c_CHECK : c_RECV;
`else
        w_next = w_last_word ? c_DONE : c_RECV;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      c_CHECK: begin
        if (bus.byte_valid_i) w_next = (bus.byte_data_i == r_sum) ? c_DONE : c_ERROR;
      end
`endif
      default: w_next = c_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it
  always_comb begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    w_byte_ready = (w_next == c_RECV) || (w_next == c_CHECK);
    w_busy       = (w_next == c_RECV) || (w_next == c_WRITE) || (w_next == c_CHECK);
`else
    w_byte_ready = (w_next == c_RECV);
    w_busy       = (w_next == c_RECV) || (w_next == c_WRITE);
`endif
    w_mem_write  = (w_next == c_WRITE);
    w_cpu_reset  = (w_next == c_DONE);
    w_done       = (w_next == c_DONE);
    w_error      = (w_next == c_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_length   <= 16'd0;
      r_word_cnt <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_asm      <= 32'd0;
      r_mem_addr <= BASE_ADDRESS;
      r_mem_data <= 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_sum      <= 8'd0;
`endif
    end else begin
      if (w_take_start) begin
        r_length   <= bus.length_i;
        r_word_cnt <= 16'd0;
        r_byte_cnt <= 2'd0;
        r_asm      <= 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        r_sum      <= 8'd0;
`endif
      end else if (w_accept) begin
        r_asm      <= w_asm_next;
        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        r_sum      <= r_sum + bus.byte_data_i;
`endif
      end else if (r_state == c_WRITE) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
      if ((r_state == c_RECV) && (w_next == c_WRITE)) begin
        r_mem_addr <= BASE_ADDRESS + {14'd0, r_word_cnt, 2'b00};
        r_mem_data <= w_asm_next;
      end
    end
  end

  assign bus.byte_ready_o  = r_byte_ready;
  assign bus.mem_write_o   = r_mem_write;
  assign bus.mem_address_o = r_mem_addr;
  assign bus.mem_data_o    = r_mem_data;
  assign bus.cpu_reset_o   = r_cpu_reset;
  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.error_o       = r_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
//==============================================================================
// tb_program_loader: directed self-checking bench for program_loader. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if bus();

  program_loader #(.MEMORY_DEPTH(32), .BASE_ADDRESS(32'h0040_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  tb_sum;

  always @(negedge clk) begin
    if (reset && bus.mem_write_o) begin
      wa_q.push_back(bus.mem_address_o);
      wd_q.push_back(bus.mem_data_o);
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
    chk({tag, "_write"}, 32'(bus.mem_write_o), 32'd0);
    chk({tag, "_addr"},  bus.mem_address_o, 32'h0040_0000);
    chk({tag, "_data"},  bus.mem_data_o, 32'd0);
    chk({tag, "_cpurst"}, 32'(bus.cpu_reset_o), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy_o), 32'd0);
    chk({tag, "_done"},  32'(bus.done_o), 32'd0);
    chk({tag, "_error"}, 32'(bus.error_o), 32'd0);
  endtask

  task automatic start_load(input logic [15:0] len);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.length_i = len;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    tb_sum = 8'd0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got = 1'b0;
    bus.byte_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.byte_ready_o) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    bus.byte_valid_i = 1'b0;
    if (got) tb_sum = tb_sum + b;
    else begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout: byte %h never accepted", b);
    end
  endtask

  task automatic send_trailer();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(tb_sum, 0);
`endif
  endtask

  task automatic wait_end(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o || bus.error_o) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: done/error never raised", tag);
    end
  endtask

  initial begin
    logic [7:0]  b2[8];
    logic [31:0] w3[3];
    int          base;

    reset = 1'b0;
    bus.start_i = 1'b0;
    bus.length_i = 16'd0;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i = 8'hAA;
    tb_sum = 8'd0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_vals("idle");
    chk("idle_no_write", 32'(wr_cnt), 32'd0);
    bus.byte_valid_i = 1'b0;

    // Two-word load
    b2 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h34, 8'h09, 8'h00, 8'h0A};
    base = wr_cnt;
    start_load(16'd2);
    chk("start_busy",  32'(bus.busy_o), 32'd1);
    chk("start_ready", 32'(bus.byte_ready_o), 32'd1);
    chk("start_cpurst", 32'(bus.cpu_reset_o), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(b2[i], 0);
    send_trailer();
    wait_end("len2");
    chk("len2_writes", 32'(wr_cnt - base), 32'd2);
    chk("len2_a0", wa_q[base],     32'h0040_0000);
    chk("len2_d0", wd_q[base],     32'h2008_0005);
    chk("len2_a1", wa_q[base + 1], 32'h0040_0004);
    chk("len2_d1", wd_q[base + 1], 32'h3409_000A);
    chk("len2_done",   32'(bus.done_o), 32'd1);
    chk("len2_cpurst", 32'(bus.cpu_reset_o), 32'd1);
    chk("len2_busy",   32'(bus.busy_o), 32'd0);
    chk("len2_error",  32'(bus.error_o), 32'd0);
    chk("len2_hold_addr", bus.mem_address_o, 32'h0040_0004);
    chk("len2_hold_data", bus.mem_data_o, 32'h3409_000A);

    // Illegal lengths
    base = wr_cnt;
    start_load(16'd0);
    chk("len0_error",  32'(bus.error_o), 32'd1);
    chk("len0_done",   32'(bus.done_o), 32'd0);
    chk("len0_cpurst", 32'(bus.cpu_reset_o), 32'd0);
    chk("len0_busy",   32'(bus.busy_o), 32'd0);
    start_load(16'd33);
    chk("len33_error",  32'(bus.error_o), 32'd1);
    chk("len33_cpurst", 32'(bus.cpu_reset_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("badlen_no_write", 32'(wr_cnt - base), 32'd0);
    chk("badlen_hold_error", 32'(bus.error_o), 32'd1);

    // Three words with random valid gaps
    w3 = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    base = wr_cnt;
    start_load(16'd3);
    chk("len3_error_cleared", 32'(bus.error_o), 32'd0);
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 4; k++) begin
        logic [31:0] word;
        word = w3[w];
        send_byte(word[31 - 8 * k -: 8], int'($urandom_range(0, 3)));
      end
    send_trailer();
    wait_end("len3");
    chk("len3_writes", 32'(wr_cnt - base), 32'd3);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("len3_a%0d", w), wa_q[base + w], 32'h0040_0000 + 32'(4 * w));
      chk($sformatf("len3_d%0d", w), wd_q[base + w], w3[w]);
    end
    chk("len3_done", 32'(bus.done_o), 32'd1);

    // Reset mid-load, then reload from base
    start_load(16'd4);
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i), 0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b1;
    base = wr_cnt;
    start_load(16'd1);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_trailer();
    wait_end("reload");
    chk("reload_writes", 32'(wr_cnt - base), 32'd1);
    chk("reload_a0", wa_q[base], 32'h0040_0000);
    chk("reload_d0", wd_q[base], 32'hDEAD_BEEF);
    chk("reload_done", 32'(bus.done_o), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Trailer checksum: good then bad
    start_load(16'd1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h0A, 0);
    wait_end("csum_good");
    chk("csum_good_done",   32'(bus.done_o), 32'd1);
    chk("csum_good_cpurst", 32'(bus.cpu_reset_o), 32'd1);
    start_load(16'd1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h0B, 0);
    wait_end("csum_bad");
    chk("csum_bad_error",  32'(bus.error_o), 32'd1);
    chk("csum_bad_cpurst", 32'(bus.cpu_reset_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
